// File: rtl/i2s_sample_serializer.sv
// ---------------------------------------------------------------------------
// i2s_sample_serializer
//
// Output stage for the music player. Once per audio frame it loads one 16-bit
// sample and requests the next one with a single-cycle new_frame strobe. The
// loaded sample is sent as a two-channel I2S stream to the external DAC. The
// same sample goes out on both channels (mono duplicated).
//
// Parameters
//   CLK_DIV    clk cycles per bclk half-period (>= 2)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous, active-low reset
//   sample_in  signed PCM sample from the player, sampled only at frame load
//   play       1 = load sample_in, 0 = load silence (zero)
//   new_frame  one-clk pulse at each frame load (sample request)
//   bclk       I2S bit clock, period 2*CLK_DIV clk cycles, 50% duty
//   lrclk      word select, 0 = left slot, 1 = right slot
//   sdata      serial data, MSB first, changes on bclk falling edges
// ---------------------------------------------------------------------------
module i2s_sample_serializer #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        play,
    output logic        new_frame,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata
);

    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [4:0]       slot_q, slot_d;
    logic             lrclk_q, lrclk_d;
    logic [31:0]      sr_q, sr_d;
    logic             sdata_q, sdata_d;
    logic             new_frame_q, new_frame_d;

    logic             div_wrap;
    logic             fall_tick;
    logic [4:0]       slot_inc;
    logic [15:0]      load_word;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        div_wrap    = (div_q == DIV_LAST);
        // bclk is about to go high->low: this is where a new slot begins.
        fall_tick   = div_wrap && bclk_q;
        slot_inc    = slot_q + 5'd1;
        load_word   = play ? sample_in : 16'h0000;

        div_d       = div_wrap ? '0 : div_q + DIV_W'(1);
        bclk_d      = div_wrap ? ~bclk_q : bclk_q;

        slot_d      = slot_q;
        lrclk_d     = lrclk_q;
        sr_d        = sr_q;
        sdata_d     = sdata_q;
        new_frame_d = 1'b0;

        if (fall_tick) begin
            slot_d  = slot_inc;
            lrclk_d = slot_inc[4];
            // The MSB is always driven first. At a load this bit is the
            // previous frame's right-channel LSB. That gives the standard
            // one-bit delay after each lrclk edge.
            sdata_d = sr_q[31];
            if (slot_inc == 5'd0) begin
                sr_d        = {load_word, load_word};
                new_frame_d = 1'b1;
            end else begin
                sr_d        = {sr_q[30:0], 1'b0};
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            slot_q      <= 5'd31;
            lrclk_q     <= 1'b1;
            sr_q        <= '0;
            sdata_q     <= 1'b0;
            new_frame_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            slot_q      <= slot_d;
            lrclk_q     <= lrclk_d;
            sr_q        <= sr_d;
            sdata_q     <= sdata_d;
            new_frame_q <= new_frame_d;
        end
    end

    assign new_frame = new_frame_q;
    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign sdata     = sdata_q;

endmodule

// File: tb/tb_i2s_sample_serializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_sample_serializer
//
// Two instances run side by side, one with CLK_DIV=4 and one with CLK_DIV=2.
// They share the clock, reset and inputs. Every clk edge after reset release
// is logged, with the inputs sampled at that edge and the outputs after it.
// The reference model predicts each output from the edge number:
//   - frames start at edge 2d + 64d*n;
//   - each slot lasts 2d edges;
//   - the word loaded for frame n is whatever play/sample_in were at its load
//     edge.
// ---------------------------------------------------------------------------
module tb_i2s_sample_serializer;

    logic        clk;
    logic        reset;
    logic [15:0] sample_in;
    logic        play;
    logic        nf4, bclk4, lrclk4, sdata4;
    logic        nf2, bclk2, lrclk2, sdata2;

    int tests = 0;
    int fails = 0;

    // Index 0 of each 2-bit field is the CLK_DIV=4 instance, index 1 is CLK_DIV=2.
    typedef struct packed {
        logic [1:0]  bclk;
        logic [1:0]  lrclk;
        logic [1:0]  sdata;
        logic [1:0]  nf;
        logic        play;
        logic [15:0] smp;
    } rec_t;

    rec_t log_q[$];   // log_q[k-1] describes clk edge k after reset release

    i2s_sample_serializer #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .sample_in(sample_in), .play(play),
        .new_frame(nf4), .bclk(bclk4), .lrclk(lrclk4), .sdata(sdata4)
    );

    i2s_sample_serializer #(.CLK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .sample_in(sample_in), .play(play),
        .new_frame(nf2), .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clk edge: snapshot the inputs the edge will see, then the outputs.
    task automatic tick();
        rec_t r;
        r.play = play;
        r.smp  = sample_in;
        @(posedge clk);
        @(negedge clk);
        r.bclk  = {bclk2, bclk4};
        r.lrclk = {lrclk2, lrclk4};
        r.sdata = {sdata2, sdata4};
        r.nf    = {nf2, nf4};
        log_q.push_back(r);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        log_q.delete();
    endtask

    task automatic run_to(input int n_edges);
        while (log_q.size() < n_edges) tick();
    endtask

    // ---------------- reference model ----------------
    function automatic int inst_div(input int inst);
        return (inst == 0) ? 4 : 2;
    endfunction

    function automatic int load_edge(input int d, input int n);
        return 2*d + 64*d*n;
    endfunction

    function automatic int exp_slot(input int d, input int k);
        if (k < 2*d) return 31;
        return ((k - 2*d) / (2*d)) % 32;
    endfunction

    function automatic logic [15:0] exp_load_val(input int d, input int n);
        int   l;
        rec_t r;
        l = load_edge(d, n);
        if (l > log_q.size()) return 16'h0000;
        r = log_q[l-1];
        return r.play ? r.smp : 16'h0000;
    endfunction

    function automatic logic exp_sdata(input int d, input int k);
        int          s;
        int          n;
        logic [15:0] w;
        if (k < 2*d) return 1'b0;
        s = exp_slot(d, k);
        n = (k - 2*d) / (64*d);
        if (s == 0) begin
            if (n == 0) return 1'b0;
            w = exp_load_val(d, n - 1);
            return w[0];
        end
        w = exp_load_val(d, n);
        if (s <= 16) return w[16 - s];
        return w[32 - s];
    endfunction

    // Number of logged edges where any output disagrees with the model.
    function automatic int model_errors(input int inst, output int first_k);
        int   d;
        int   errs;
        rec_t r;
        logic eb, el, ed, en;
        d = inst_div(inst);
        errs = 0;
        first_k = -1;
        for (int k = 1; k <= log_q.size(); k++) begin
            r  = log_q[k-1];
            eb = ((k / d) % 2) == 1;
            el = exp_slot(d, k) >= 16;
            ed = exp_sdata(d, k);
            en = (k >= 2*d) && (((k - 2*d) % (64*d)) == 0);
            if (r.bclk[inst] !== eb || r.lrclk[inst] !== el ||
                r.sdata[inst] !== ed || r.nf[inst] !== en) begin
                if (errs == 0) first_k = k;
                errs++;
            end
        end
        return errs;
    endfunction

    // Word rebuilt from sdata as a receiver sees it on each bclk rise.
    function automatic logic [15:0] obs_word(input int inst, input int n, input bit right);
        int          d;
        int          l;
        int          k;
        logic [15:0] w;
        d = inst_div(inst);
        l = load_edge(d, n);
        w = 'x;
        if (!right) begin
            for (int s = 1; s <= 16; s++) begin
                k = l + 2*d*s + d;
                if (k <= log_q.size()) w[16 - s] = log_q[k-1].sdata[inst];
            end
        end else begin
            for (int s = 17; s <= 31; s++) begin
                k = l + 2*d*s + d;
                if (k <= log_q.size()) w[32 - s] = log_q[k-1].sdata[inst];
            end
            k = load_edge(d, n + 1) + d;
            if (k <= log_q.size()) w[0] = log_q[k-1].sdata[inst];
        end
        return w;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int errs;
        int first;
        play = 1'b1;
        sample_in = 16'($urandom);
        reset = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({log_q[$].bclk[i], log_q[$].lrclk[i], log_q[$].sdata[i], log_q[$].nf[i]} !== 4'b0100) begin
                fails++;
                $display("FAIL reset_values inst%0d: bclk/lrclk/sdata/nf=%b expected 0100", i,
                         {log_q[$].bclk[i], log_q[$].lrclk[i], log_q[$].sdata[i], log_q[$].nf[i]});
            end
        end
        reset = 1'b1;
        log_q.delete();
        run_to(2*4 + 64*4*2 + 8);
        tests++;
        if (log_q[2].bclk[0] !== 1'b0 || log_q[3].bclk[0] !== 1'b1) begin
            fails++;
            $display("FAIL first_bclk_rise: edge3=%b edge4=%b expected 0 1", log_q[2].bclk[0], log_q[3].bclk[0]);
        end
        tests++;
        if ({log_q[6].nf[0], log_q[7].nf[0], log_q[8].nf[0]} !== 3'b010) begin
            fails++;
            $display("FAIL first_new_frame: edges 7..9 = %b expected 010",
                     {log_q[6].nf[0], log_q[7].nf[0], log_q[8].nf[0]});
        end
        tests++;
        if ({log_q[262].nf[0], log_q[263].nf[0], log_q[264].nf[0]} !== 3'b010) begin
            fails++;
            $display("FAIL second_new_frame: edges 263..265 = %b expected 010",
                     {log_q[262].nf[0], log_q[263].nf[0], log_q[264].nf[0]});
        end
        for (int i = 0; i < 2; i++) begin
            errs = model_errors(i, first);
            tests++;
            if (errs !== 0) begin
                fails++;
                $display("FAIL startup_waveform inst%0d: %0d edges differ, first at edge %0d, expected 0", i, errs, first);
            end
        end
    endtask

    task automatic test_hold_a5c3();
        int errs;
        int first;
        int k;
        play = 1'b1;
        sample_in = 16'hA5C3;
        do_reset();
        run_to(load_edge(4, 2) + 4 + 2);
        for (int n = 0; n < 2; n++) begin
            tests++;
            if (obs_word(0, n, 0) !== 16'hA5C3) begin
                fails++;
                $display("FAIL a5c3_left f%0d: got %h expected a5c3", n, obs_word(0, n, 0));
            end
            tests++;
            if (obs_word(0, n, 1) !== 16'hA5C3) begin
                fails++;
                $display("FAIL a5c3_right f%0d: got %h expected a5c3", n, obs_word(0, n, 1));
            end
        end
        for (int s = 14; s <= 17; s++) begin
            k = load_edge(4, 0) + 8*s + 4;
            tests++;
            if (log_q[k-1].lrclk[0] !== (s >= 16)) begin
                fails++;
                $display("FAIL a5c3_lrclk slot%0d: got %b expected %b", s, log_q[k-1].lrclk[0], s >= 16);
            end
        end
        errs = model_errors(0, first);
        tests++;
        if (errs !== 0) begin
            fails++;
            $display("FAIL a5c3_waveform: %0d edges differ, first at edge %0d, expected 0", errs, first);
        end
    endtask

    task automatic test_pacing();
        int errs;
        int first;
        int wait_cnt;
        logic [15:0] val;
        play = 1'b1;
        val = 16'h0001;
        sample_in = val;
        do_reset();
        wait_cnt = -1;
        while (log_q.size() < load_edge(4, 11) + 4 + 2) begin
            tick();
            if (log_q[$].nf[0] === 1'b1) wait_cnt = 3;
            else if (wait_cnt > 0) wait_cnt--;
            if (wait_cnt == 0) begin
                val = val + 16'h0001;
                sample_in = val;
                wait_cnt = -1;
            end
        end
        for (int n = 0; n < 10; n++) begin
            tests++;
            if (obs_word(0, n, 0) !== 16'(n + 1) || obs_word(0, n, 1) !== 16'(n + 1)) begin
                fails++;
                $display("FAIL pacing f%0d: left %h right %h expected %h", n,
                         obs_word(0, n, 0), obs_word(0, n, 1), 16'(n + 1));
            end
        end
        for (int i = 0; i < 2; i++) begin
            errs = model_errors(i, first);
            tests++;
            if (errs !== 0) begin
                fails++;
                $display("FAIL pacing_waveform inst%0d: %0d edges differ, first at edge %0d, expected 0", i, errs, first);
            end
        end
    endtask

    task automatic test_random();
        int errs;
        int first;
        play = 1'b1;
        sample_in = 16'($urandom);
        do_reset();
        while (log_q.size() < load_edge(4, 3) + 8) begin
            tick();
            if ($urandom_range(0, 15) == 0) sample_in = 16'($urandom);
            if ($urandom_range(0, 199) == 0) play = ~play;
        end
        for (int n = 0; n < 3; n++) begin
            tests++;
            if (obs_word(0, n, 0) !== exp_load_val(4, n) || obs_word(0, n, 1) !== exp_load_val(4, n)) begin
                fails++;
                $display("FAIL random_word f%0d: left %h right %h expected %h", n,
                         obs_word(0, n, 0), obs_word(0, n, 1), exp_load_val(4, n));
            end
        end
        for (int i = 0; i < 2; i++) begin
            errs = model_errors(i, first);
            tests++;
            if (errs !== 0) begin
                fails++;
                $display("FAIL random_waveform inst%0d: %0d edges differ, first at edge %0d, expected 0", i, errs, first);
            end
        end
    endtask

    task automatic test_mute();
        int errs;
        int first;
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h7FFF;
        exp_w[1] = 16'h0000;
        exp_w[2] = 16'h7FFF;
        play = 1'b1;
        sample_in = 16'h7FFF;
        do_reset();
        run_to(load_edge(4, 0) + 128);
        play = 1'b0;
        run_to(load_edge(4, 1) + 128);
        play = 1'b1;
        run_to(load_edge(4, 3) + 4 + 2);
        for (int n = 0; n < 3; n++) begin
            tests++;
            if (obs_word(0, n, 0) !== exp_w[n] || obs_word(0, n, 1) !== exp_w[n]) begin
                fails++;
                $display("FAIL mute f%0d: left %h right %h expected %h", n,
                         obs_word(0, n, 0), obs_word(0, n, 1), exp_w[n]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            errs = model_errors(i, first);
            tests++;
            if (errs !== 0) begin
                fails++;
                $display("FAIL mute_waveform inst%0d: %0d edges differ, first at edge %0d, expected 0", i, errs, first);
            end
        end
    endtask

    task automatic test_reset_mid();
        int errs;
        int first;
        play = 1'b1;
        sample_in = 16'hFFFF;
        do_reset();
        // Stop inside slot 20 of the CLK_DIV=4 instance, while bclk is high.
        run_to(load_edge(4, 0) + 8*20 + 4 + 1);
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({(i == 0) ? bclk4 : bclk2, (i == 0) ? lrclk4 : lrclk2,
                 (i == 0) ? sdata4 : sdata2, (i == 0) ? nf4 : nf2} !== 4'b0100) begin
                fails++;
                $display("FAIL async_reset inst%0d: bclk/lrclk/sdata/nf=%b expected 0100", i,
                         {(i == 0) ? bclk4 : bclk2, (i == 0) ? lrclk4 : lrclk2,
                          (i == 0) ? sdata4 : sdata2, (i == 0) ? nf4 : nf2});
            end
        end
        repeat (2) tick();
        reset = 1'b1;
        log_q.delete();
        run_to(2*4 + 64*4*2 + 8);
        tests++;
        if ({log_q[6].nf[0], log_q[7].nf[0], log_q[8].nf[0]} !== 3'b010 ||
            {log_q[262].nf[0], log_q[263].nf[0]} !== 2'b01) begin
            fails++;
            $display("FAIL restart_new_frame: edges 7..9 = %b, 263..264 = %b expected 010 01",
                     {log_q[6].nf[0], log_q[7].nf[0], log_q[8].nf[0]}, {log_q[262].nf[0], log_q[263].nf[0]});
        end
        for (int i = 0; i < 2; i++) begin
            errs = model_errors(i, first);
            tests++;
            if (errs !== 0) begin
                fails++;
                $display("FAIL restart_waveform inst%0d: %0d edges differ, first at edge %0d, expected 0", i, errs, first);
            end
        end
    endtask

    task automatic test_clkdiv2();
        int errs;
        int first;
        play = 1'b1;
        sample_in = 16'h8001;
        do_reset();
        run_to(load_edge(2, 3) + 2 + 2);
        tests++;
        if ({log_q[0].bclk[1], log_q[1].bclk[1], log_q[3].bclk[1], log_q[5].bclk[1]} !== 4'b0101) begin
            fails++;
            $display("FAIL div2_bclk: edges 1,2,4,6 = %b expected 0101",
                     {log_q[0].bclk[1], log_q[1].bclk[1], log_q[3].bclk[1], log_q[5].bclk[1]});
        end
        tests++;
        if ({log_q[2].nf[1], log_q[3].nf[1], log_q[130].nf[1], log_q[131].nf[1]} !== 4'b0101) begin
            fails++;
            $display("FAIL div2_new_frame: edges 3,4,131,132 = %b expected 0101",
                     {log_q[2].nf[1], log_q[3].nf[1], log_q[130].nf[1], log_q[131].nf[1]});
        end
        for (int n = 0; n < 2; n++) begin
            tests++;
            if (obs_word(1, n, 0) !== 16'h8001 || obs_word(1, n, 1) !== 16'h8001) begin
                fails++;
                $display("FAIL div2_word f%0d: left %h right %h expected 8001", n,
                         obs_word(1, n, 0), obs_word(1, n, 1));
            end
        end
        errs = model_errors(1, first);
        tests++;
        if (errs !== 0) begin
            fails++;
            $display("FAIL div2_waveform: %0d edges differ, first at edge %0d, expected 0", errs, first);
        end
    endtask

    initial begin
        reset = 1'b0;
        play = 1'b0;
        sample_in = 16'h0000;
        test_reset();
        test_hold_a5c3();
        test_pacing();
        test_random();
        test_mute();
        test_reset_mid();
        test_clkdiv2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_sample_serializer.md
# i2s_sample_serializer

Downstream output stage for the music player: it paces playback by requesting one 16-bit sample per audio frame with a single-cycle `new_frame` strobe, and receives that sample on `sample_in`. Each sample is serialized as a mono-duplicated, two-channel I2S stream (`bclk`, `lrclk`, `sdata`) to the external DAC. The strobe drives the player's `New_Frame` input, and `sample_in` is driven by the player's `sample_out`.

## Interface
- `CLK_DIV`, default 4: clk cycles per bclk half-period; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (`reset=0` resets).
- `sample_in`  in  16  signed PCM sample from the player; sampled only at frame load.
- `play`  in  1  1 = output `sample_in`; 0 = load zero (mute).
- `new_frame`  out  1  one-clk pulse at each frame load; requests the next sample.
- `bclk`  out  1  I2S bit clock: period 2·CLK_DIV clk cycles, 50% duty.
- `lrclk`  out  1  word select: 0 = left slot, 1 = right slot.
- `sdata`  out  1  serial data, MSB first; changes on bclk falling edges.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - At CLK_DIV-1, `bclk` toggles.
  - `fall_tick` = (`div_cnt`==CLK_DIV-1) && (`bclk`==1).
- Slot counter `slot` is 5 bits and advances by 1 (mod 32) on each `fall_tick`. Every register update below happens only on `fall_tick`, using the new slot value k.
- `lrclk` <= k[4]: low for slots 0–15, high for slots 16–31.
- k == 0 (frame load):
  - `sdata` <= `sr[31]`, which is the previous frame's right-channel LSB.
  - `sr` <= {s, s}, where s = `play` ? `sample_in` : 16'h0000.
  - `new_frame` <= 1 for exactly one clk cycle.
- k = 1..31: `sdata` <= `sr[31]`; `sr` <= {`sr[30:0]`, 1'b0}.
- Resulting bit map (standard I2S, one-bit delay after the `lrclk` edge):
  - slots 1–16: left bits 15..0;
  - slots 17–31: right bits 15..1;
  - slot 0 of the next frame: right bit 0.
- `new_frame` is 0 in every cycle other than the load-edge cycle.
- `play` is sampled only at load. A change mid-frame never alters the frame already in `sr`.
- `sample_in` may change at any time. The upstream player must present the next value within one frame (64·CLK_DIV clk cycles) of the `new_frame` pulse.
- No arithmetic on sample data; bits are passed through unchanged (two's complement preserved).

## Timing
- Reset values (applied immediately while `reset`=0):
  - `div_cnt`=0, `bclk`=0, `slot`=31, `lrclk`=1;
  - `sr`=0, `sdata`=0, `new_frame`=0.
- After reset release:
  - First `bclk` rise on clk edge CLK_DIV.
  - First `fall_tick` (frame load, `new_frame`=1) on clk edge 2·CLK_DIV.
  - Frame period: exactly 64·CLK_DIV clk cycles; `new_frame` pulses are spaced exactly that far apart.
- Latency: a sample latched at load appears on `sdata` from the next `fall_tick` (MSB, slot 1). Its right-channel LSB is driven at the following load.
- `lrclk` and `sdata` change only on `bclk` falling edges; receivers sample on `bclk` rising edges.
- Reset mid-frame: all outputs return to their reset values asynchronously. The partial frame is discarded, and the restart sequence is identical to the initial one.

## Test plan
- Reset then release with CLK_DIV=4:
  - `bclk`=0, `lrclk`=1, `sdata`=0, `new_frame`=0 during reset;
  - first `new_frame` pulse at clk edge 8 after release, width 1 cycle;
  - later pulses every 256 cycles.
- `play`=1, `sample_in`=16'hA5C3 held:
  - bits captured on `bclk` rise in slots 1–16 = A5C3 MSB-first;
  - slots 17–31 plus the next slot 0 = A5C3 again;
  - `lrclk` low for slots 0–15, high for slots 16–31.
- Pacing: `sample_in` changes to the next value of a ramp (0x0001, 0x0002, ...) 3 cycles after each `new_frame`; each frame carries the value present at its load, with no sample skipped or repeated over 10 frames.
- Mute: `play`=0 from mid-frame with `sample_in`=16'h7FFF:
  - current frame finishes as 7FFF;
  - next frame is all-zero on both channels;
  - setting `play`=1 restores data at the following load.
- Reset asserted at slot 20: all outputs go to reset values within the same cycle (asynchronous); the timing after release matches the first scenario exactly.
- CLK_DIV=2 with `sample_in`=16'h8001: `bclk` period 4 clk cycles; frame 128 cycles; the serialized bits are 1000_0000_0000_0001 on both channels.
